watch_timekeeper: RTL

WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

---
 rtl/watch_pkg.sv | 20 ++
 rtl/wrap_counter.sv | 39 +++
 rtl/watch_timekeeper.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared constants for the watch timekeeper: field limits, field width,
// flash_mode edit-select encodings and the run/edit state type.
package watch_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int FIELD_W  = 6;

    localparam logic [1:0] FM_RUN   = 2'b00;
    localparam logic [1:0] FM_SECS  = 2'b01;
    localparam logic [1:0] FM_MINS  = 2'b10;
    localparam logic [1:0] FM_HOURS = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } watch_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) field counter with a clamped parallel load; o_carry marks
// the increment that wraps MAX back to zero so the next field can advance.
module wrap_counter #(
    parameter int MAX   = 59,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_value;
    logic             w_at_max;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max       = (r_value == MAX_V);
    assign w_load_clamped = (i_load_val > MAX_V) ? MAX_V : i_load_val;
    // Load has priority, so a wrap never propagates while the field is being edited.
    assign o_carry        = i_inc && w_at_max && !i_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= w_load_clamped;
        end else if (i_inc) begin
            r_value <= w_at_max ? '0 : r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/watch_timekeeper.sv
// Watch timekeeper: seconds prescaler, hh:mm:ss counters with edit loading
// and optional edit-field blink (enabled by defining WATCH_BLINK_EN).
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         flash_mode,
    input  logic [FIELD_W-1:0] secs_mode,
    input  logic [FIELD_W-1:0] mins_mode,
    input  logic [FIELD_W-1:0] hours_mode,
    output logic [FIELD_W-1:0] secs,
    output logic [FIELD_W-1:0] mins,
    output logic [FIELD_W-1:0] hours,
    output logic               sec_tick,
    output logic               blank_secs,
    output logic               blank_mins,
    output logic               blank_hours,
    output watch_state_e       dbg_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    watch_state_e r_state;
    watch_state_e w_next_state;
    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic          w_edit;
    logic          w_tick;
    logic          w_secs_carry;
    logic          w_mins_carry;
    logic          w_hours_carry_unused;

    always_comb begin
        w_next_state = ST_RUN;
        if (flash_mode != FM_RUN) begin
            w_next_state = ST_EDIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Behaviour on each edge follows the incoming mode, so an edit request
    // arriving on the terminal prescaler count suppresses that tick.
    assign w_edit = (w_next_state == ST_EDIT);
    assign w_tick = !w_edit && (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_presc    <= (w_edit || w_tick) ? '0 : r_presc + 1'b1;
            r_sec_tick <= w_tick;
        end
    end

    wrap_counter #(.MAX(SEC_MAX), .WIDTH(FIELD_W)) u_secs (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_edit && (flash_mode == FM_SECS)),
        .i_load_val (secs_mode),
        .i_inc      (w_tick),
        .o_value    (secs),
        .o_carry    (w_secs_carry)
    );

    wrap_counter #(.MAX(MIN_MAX), .WIDTH(FIELD_W)) u_mins (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_edit && (flash_mode == FM_MINS)),
        .i_load_val (mins_mode),
        .i_inc      (w_secs_carry),
        .o_value    (mins),
        .o_carry    (w_mins_carry)
    );

    wrap_counter #(.MAX(HOUR_MAX), .WIDTH(FIELD_W)) u_hours (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_edit && (flash_mode == FM_HOURS)),
        .i_load_val (hours_mode),
        .i_inc      (w_mins_carry),
        .o_value    (hours),
        .o_carry    (w_hours_carry_unused)
    );

    assign sec_tick  = r_sec_tick;
    assign dbg_state = r_state;

`ifdef WATCH_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_cnt_next;
    logic          r_blink_phase;
    logic          w_blink_phase_next;
    logic          r_blank_secs;
    logic          r_blank_mins;
    logic          r_blank_hours;

    // The first edit cycle starts from count 0 / phase 0; the counter only
    // advances once the FSM is already in EDIT.
    always_comb begin
        w_blink_cnt_next   = '0;
        w_blink_phase_next = 1'b0;
        if (w_edit && (r_state == ST_EDIT)) begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                w_blink_cnt_next   = '0;
                w_blink_phase_next = !r_blink_phase;
            end else begin
                w_blink_cnt_next   = r_blink_cnt + 1'b1;
                w_blink_phase_next = r_blink_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blank_secs  <= 1'b0;
            r_blank_mins  <= 1'b0;
            r_blank_hours <= 1'b0;
        end else begin
            r_blink_cnt   <= w_blink_cnt_next;
            r_blink_phase <= w_blink_phase_next;
            r_blank_secs  <= w_blink_phase_next && (flash_mode == FM_SECS);
            r_blank_mins  <= w_blink_phase_next && (flash_mode == FM_MINS);
            r_blank_hours <= w_blink_phase_next && (flash_mode == FM_HOURS);
        end
    end

    assign blank_secs  = r_blank_secs;
    assign blank_mins  = r_blank_mins;
    assign blank_hours = r_blank_hours;
`else
    assign blank_secs  = 1'b0;
    assign blank_mins  = 1'b0;
    assign blank_hours = 1'b0;
`endif

endmodule
